// File: rtl/branch_redirect_pkg.sv
// Shared types and constants for the retirement-side branch redirect logic.
package redirect_pkg;

  localparam int unsigned RETIRE_WIDTH = 5;
  localparam int unsigned PHT_INDEX_W  = 10;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FLUSH   = 2'd1,
    RECOVER = 2'd2
  } redirect_state_t;

  typedef struct packed {
    logic                   valid;
    logic                   is_branch;
    logic                   taken;
    logic                   predict;
    logic [PHT_INDEX_W-1:0] index;
    logic [31:0]            target_unsel;
  } retire_slot_t;

  function automatic logic [2:0] count_ones(input logic [RETIRE_WIDTH-1:0] v);
    logic [2:0] n;
    n = '0;
    for (int unsigned i = 0; i < RETIRE_WIDTH; i++) begin
      n = n + 3'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/branch_redirect_mispredict_sel.sv
// Priority finder: lowest mispredicting slot, plus a mask of every younger slot.
module mispredict_sel
  import redirect_pkg::*;
(
  input  logic [RETIRE_WIDTH-1:0] mp_i,
  output logic                    found_o,
  output logic [2:0]              k_o,
  output logic [RETIRE_WIDTH-1:0] squash_o
);

  always_comb begin
    found_o  = 1'b0;
    k_o      = '0;
    squash_o = '0;
    for (int unsigned i = 0; i < RETIRE_WIDTH; i++) begin
      if (found_o) begin
        squash_o[i] = 1'b1;
      end else if (mp_i[i]) begin
        found_o = 1'b1;
        k_o     = 3'(i);
      end
    end
  end

endmodule

// File: rtl/branch_redirect.sv
// Retirement-side PHT update and mispredict flush/redirect sequencer.
// Optional saturating statistics counters under `BRANCH_REDIRECT_STATS_EN.
module branch_redirect
  import redirect_pkg::*;
#(
  parameter int unsigned RECOVER_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      valid_retire,
  input  logic [4:0]      isBranch_retire,
  input  logic [4:0]      taken_retire,
  input  logic [4:0]      Predict_retire,
  input  logic [4:0][9:0] index_retire,
  input  logic [4:0][31:0] target_unsel_retire,
  output logic            ready_retire,
  output logic [4:0][9:0] index_rob,
  output logic [4:0]      Branch_rob,
  output logic [4:0]      valid_update_rob,
  output logic            flush_pc,
  output logic            flush_ifr,
  output logic            flush_ififo,
  output logic            flush_backend,
`ifdef BRANCH_REDIRECT_STATS_EN
  output logic [31:0]     cnt_branch,
  output logic [31:0]     cnt_mispredict,
`endif
  output logic [31:0]     target_unsel_rob
);

  redirect_state_t state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [31:0]     target_q, target_d;

  retire_slot_t [RETIRE_WIDTH-1:0] slot;
  logic [RETIRE_WIDTH-1:0] mp_cand, squash, accepted, upd_d, upd_q, br_d, br_q;
  logic [RETIRE_WIDTH-1:0][PHT_INDEX_W-1:0] idx_d, idx_q;
  logic       found;
  logic [2:0] k;

  always_comb begin
    for (int unsigned i = 0; i < RETIRE_WIDTH; i++) begin
      slot[i].valid        = valid_retire[i];
      slot[i].is_branch    = isBranch_retire[i];
      slot[i].taken        = taken_retire[i];
      slot[i].predict      = Predict_retire[i];
      slot[i].index        = index_retire[i];
      slot[i].target_unsel = target_unsel_retire[i];
    end
  end

  assign ready_retire = (state_q == IDLE);

  // The lowest candidate is always accepted, since any older candidate would be lower.
  always_comb begin
    for (int unsigned i = 0; i < RETIRE_WIDTH; i++) begin
      mp_cand[i] = ready_retire & slot[i].valid & slot[i].is_branch
                 & (slot[i].taken ^ slot[i].predict);
    end
  end

  mispredict_sel u_sel (
    .mp_i     (mp_cand),
    .found_o  (found),
    .k_o      (k),
    .squash_o (squash)
  );

  always_comb begin
    for (int unsigned i = 0; i < RETIRE_WIDTH; i++) begin
      accepted[i] = ready_retire & slot[i].valid & ~squash[i];
      upd_d[i]    = accepted[i] & slot[i].is_branch;
      br_d[i]     = upd_d[i] & slot[i].taken;
      idx_d[i]    = upd_d[i] ? slot[i].index : '0;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    target_d = target_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d  = FLUSH;
          target_d = slot[k].target_unsel;
        end
      end
      FLUSH: begin
        state_d = RECOVER;
        cnt_d   = 4'(RECOVER_CYCLES - 1);
      end
      RECOVER: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      target_q <= '0;
      upd_q    <= '0;
      br_q     <= '0;
      idx_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      target_q <= target_d;
      upd_q    <= upd_d;
      br_q     <= br_d;
      idx_q    <= idx_d;
    end
  end

  assign valid_update_rob = upd_q;
  assign Branch_rob       = br_q;
  assign index_rob        = idx_q;
  assign flush_pc         = (state_q == FLUSH);
  assign flush_ifr        = (state_q == FLUSH);
  assign flush_ififo      = (state_q == FLUSH);
  assign flush_backend    = (state_q == FLUSH);
  assign target_unsel_rob = (state_q == FLUSH) ? target_q : '0;

`ifdef BRANCH_REDIRECT_STATS_EN
  logic [31:0] cnt_branch_q, cnt_branch_d;
  logic [31:0] cnt_mispredict_q, cnt_mispredict_d;
  logic [32:0] br_sum;

  always_comb begin
    br_sum       = {1'b0, cnt_branch_q} + 33'(count_ones(upd_d));
    cnt_branch_d = br_sum[32] ? '1 : br_sum[31:0];
    cnt_mispredict_d = cnt_mispredict_q;
    if (state_q == IDLE && found && cnt_mispredict_q != '1) begin
      cnt_mispredict_d = cnt_mispredict_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_branch_q     <= '0;
      cnt_mispredict_q <= '0;
    end else begin
      cnt_branch_q     <= cnt_branch_d;
      cnt_mispredict_q <= cnt_mispredict_d;
    end
  end

  assign cnt_branch     = cnt_branch_q;
  assign cnt_mispredict = cnt_mispredict_q;
`endif

endmodule

// File: tb/tb_branch_redirect.sv
// Directed self-checking bench for branch_redirect (RECOVER_CYCLES = 2).
module tb_branch_redirect;

  logic             clk;
  logic             rst;
  logic [4:0]       valid_retire, isBranch_retire, taken_retire, Predict_retire;
  logic [4:0][9:0]  index_retire;
  logic [4:0][31:0] target_unsel_retire;
  logic             ready_retire;
  logic [4:0][9:0]  index_rob;
  logic [4:0]       Branch_rob, valid_update_rob;
  logic             flush_pc, flush_ifr, flush_ififo, flush_backend;
  logic [31:0]      target_unsel_rob;
`ifdef BRANCH_REDIRECT_STATS_EN
  logic [31:0]      cnt_branch, cnt_mispredict;
`endif

  int errors = 0;
  int checks = 0;

  branch_redirect #(.RECOVER_CYCLES(2)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .valid_retire        (valid_retire),
    .isBranch_retire     (isBranch_retire),
    .taken_retire        (taken_retire),
    .Predict_retire      (Predict_retire),
    .index_retire        (index_retire),
    .target_unsel_retire (target_unsel_retire),
    .ready_retire        (ready_retire),
    .index_rob           (index_rob),
    .Branch_rob          (Branch_rob),
    .valid_update_rob    (valid_update_rob),
    .flush_pc            (flush_pc),
    .flush_ifr           (flush_ifr),
    .flush_ififo         (flush_ififo),
    .flush_backend       (flush_backend),
`ifdef BRANCH_REDIRECT_STATS_EN
    .cnt_branch          (cnt_branch),
    .cnt_mispredict      (cnt_mispredict),
`endif
    .target_unsel_rob    (target_unsel_rob)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    valid_retire        = '0;
    isBranch_retire     = '0;
    taken_retire        = '0;
    Predict_retire      = '0;
    index_retire        = '0;
    target_unsel_retire = '0;
  endtask

  task automatic set_slot(input int s, input logic br, input logic tk, input logic pr,
                          input logic [9:0] idx, input logic [31:0] tgt);
    valid_retire[s]        = 1'b1;
    isBranch_retire[s]     = br;
    taken_retire[s]        = tk;
    Predict_retire[s]      = pr;
    index_retire[s]        = idx;
    target_unsel_retire[s] = tgt;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if (ready_retire !== 1'b1) begin
      errors++; $display("FAIL reset_ready got=%b exp=1", ready_retire);
    end
    checks++;
    if ({valid_update_rob, Branch_rob} !== 10'b0) begin
      errors++; $display("FAIL reset_update got=%b/%b exp=0", valid_update_rob, Branch_rob);
    end
    checks++;
    if ({flush_pc, flush_ifr, flush_ififo, flush_backend} !== 4'b0) begin
      errors++; $display("FAIL reset_flush got=%b exp=0000",
                         {flush_pc, flush_ifr, flush_ififo, flush_backend});
    end
    checks++;
    if (index_rob !== 50'b0 || target_unsel_rob !== 32'h0) begin
      errors++; $display("FAIL reset_regs index=%h target=%h exp=0", index_rob, target_unsel_rob);
    end
  endtask

  task automatic test_nonbranch();
    clear_inputs();
    for (int s = 0; s < 5; s++) set_slot(s, 1'b0, 1'b1, 1'b0, 10'(s + 1), 32'h40 * s);
    tick();
    clear_inputs();
    checks++;
    if (valid_update_rob !== 5'b0) begin
      errors++; $display("FAIL nonbranch_update got=%b exp=00000", valid_update_rob);
    end
    checks++;
    if (flush_pc !== 1'b0 || ready_retire !== 1'b1) begin
      errors++; $display("FAIL nonbranch_ctrl flush=%b ready=%b exp=0/1", flush_pc, ready_retire);
    end
  endtask

  task automatic test_correct_predict();
    clear_inputs();
    set_slot(0, 1'b1, 1'b1, 1'b1, 10'h005, 32'h0);
    set_slot(2, 1'b1, 1'b1, 1'b1, 10'h1FF, 32'h0);
    tick();
    clear_inputs();
    checks++;
    if (valid_update_rob !== 5'b00101) begin
      errors++; $display("FAIL correct_update got=%b exp=00101", valid_update_rob);
    end
    checks++;
    if (index_rob[2] !== 10'h1FF || index_rob[0] !== 10'h005) begin
      errors++; $display("FAIL correct_index got=%h/%h exp=1ff/005", index_rob[2], index_rob[0]);
    end
    checks++;
    if (Branch_rob[2] !== 1'b1 || Branch_rob[0] !== 1'b1) begin
      errors++; $display("FAIL correct_dir got=%b exp=xx1x1", Branch_rob);
    end
    checks++;
    if (flush_pc !== 1'b0 || ready_retire !== 1'b1) begin
      errors++; $display("FAIL correct_ctrl flush=%b ready=%b exp=0/1", flush_pc, ready_retire);
    end
    tick();
    checks++;
    if (valid_update_rob !== 5'b0) begin
      errors++; $display("FAIL correct_oneshot got=%b exp=00000", valid_update_rob);
    end
  endtask

  task automatic test_mispredict();
    int low;
    clear_inputs();
    set_slot(1, 1'b1, 1'b0, 1'b1, 10'h0AA, 32'h1C000040);
    set_slot(3, 1'b1, 1'b1, 1'b1, 10'h0BB, 32'h0);
    tick();
    // Keep presenting a mispredicting branch; it must be ignored while blocked.
    clear_inputs();
    set_slot(0, 1'b1, 1'b1, 1'b0, 10'h3FF, 32'hDEAD0000);
    checks++;
    if (valid_update_rob !== 5'b00010 || index_rob[1] !== 10'h0AA || Branch_rob[1] !== 1'b0) begin
      errors++; $display("FAIL mp_update got=%b idx=%h dir=%b exp=00010/0aa/0",
                         valid_update_rob, index_rob[1], Branch_rob[1]);
    end
    checks++;
    if ({flush_pc, flush_ifr, flush_ififo, flush_backend} !== 4'b1111) begin
      errors++; $display("FAIL mp_flush got=%b exp=1111",
                         {flush_pc, flush_ifr, flush_ififo, flush_backend});
    end
    checks++;
    if (target_unsel_rob !== 32'h1C000040) begin
      errors++; $display("FAIL mp_target got=%h exp=1c000040", target_unsel_rob);
    end
    low = 0;
    for (int c = 0; c < 10 && ready_retire === 1'b0; c++) begin
      low++;
      tick();
      if (low == 1) begin
        checks++;
        if (flush_pc !== 1'b0 || valid_update_rob !== 5'b0) begin
          errors++; $display("FAIL mp_recover flush=%b upd=%b exp=0/00000",
                             flush_pc, valid_update_rob);
        end
      end
    end
    clear_inputs();
    checks++;
    if (low !== 3) begin
      errors++; $display("FAIL mp_ready_low got=%0d exp=3 cycles", low);
    end
    tick();
    checks++;
    if (flush_pc !== 1'b0 || ready_retire !== 1'b1) begin
      errors++; $display("FAIL mp_ignored flush=%b ready=%b exp=0/1", flush_pc, ready_retire);
    end
  endtask

  task automatic test_multi_mispredict();
    int waited;
    clear_inputs();
    set_slot(0, 1'b1, 1'b1, 1'b0, 10'h011, 32'h100);
    set_slot(4, 1'b1, 1'b0, 1'b1, 10'h044, 32'h200);
    tick();
    clear_inputs();
    checks++;
    if (target_unsel_rob !== 32'h100 || flush_pc !== 1'b1) begin
      errors++; $display("FAIL multi_target got=%h flush=%b exp=100/1", target_unsel_rob, flush_pc);
    end
    checks++;
    if (valid_update_rob !== 5'b00001 || Branch_rob[0] !== 1'b1) begin
      errors++; $display("FAIL multi_update got=%b dir=%b exp=00001/1",
                         valid_update_rob, Branch_rob[0]);
    end
    waited = 0;
    while (ready_retire !== 1'b1 && waited < 20) begin
      tick();
      waited++;
      checks++;
      if (flush_pc !== 1'b0) begin
        errors++; $display("FAIL multi_single_flush got=%b exp=0", flush_pc);
      end
    end
    checks++;
    if (ready_retire !== 1'b1) begin
      errors++; $display("FAIL multi_timeout ready=%b exp=1", ready_retire);
    end
  endtask

  task automatic test_reset_in_flush();
    clear_inputs();
    set_slot(2, 1'b1, 1'b0, 1'b1, 10'h077, 32'h00ABCDEF);
    tick();
    clear_inputs();
    checks++;
    if (flush_pc !== 1'b1) begin
      errors++; $display("FAIL rstflush_enter got=%b exp=1", flush_pc);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (ready_retire !== 1'b1 ||
        {flush_pc, flush_ifr, flush_ififo, flush_backend} !== 4'b0) begin
      errors++; $display("FAIL rstflush_idle ready=%b flush=%b exp=1/0000", ready_retire,
                         {flush_pc, flush_ifr, flush_ififo, flush_backend});
    end
    tick();
    checks++;
    if (ready_retire !== 1'b1 || flush_pc !== 1'b0) begin
      errors++; $display("FAIL rstflush_stay ready=%b flush=%b exp=1/0", ready_retire, flush_pc);
    end
  endtask

  task automatic test_back_to_back();
    clear_inputs();
    set_slot(4, 1'b1, 1'b0, 1'b0, 10'h123, 32'h0);
    tick();
    clear_inputs();
    set_slot(3, 1'b1, 1'b1, 1'b1, 10'h321, 32'h0);
    set_slot(0, 1'b0, 1'b1, 1'b0, 10'h001, 32'h0);
    checks++;
    if (valid_update_rob !== 5'b10000 || index_rob[4] !== 10'h123 || Branch_rob[4] !== 1'b0) begin
      errors++; $display("FAIL b2b_first got=%b idx=%h dir=%b exp=10000/123/0",
                         valid_update_rob, index_rob[4], Branch_rob[4]);
    end
    tick();
    clear_inputs();
    checks++;
    if (valid_update_rob !== 5'b01000 || index_rob[3] !== 10'h321 || Branch_rob[3] !== 1'b1) begin
      errors++; $display("FAIL b2b_second got=%b idx=%h dir=%b exp=01000/321/1",
                         valid_update_rob, index_rob[3], Branch_rob[3]);
    end
    tick();
    checks++;
    if (valid_update_rob !== 5'b0 || flush_pc !== 1'b0) begin
      errors++; $display("FAIL b2b_idle got=%b flush=%b exp=00000/0", valid_update_rob, flush_pc);
    end
  endtask

`ifdef BRANCH_REDIRECT_STATS_EN
  task automatic test_stats_saturate();
    clear_inputs();
    force dut.cnt_branch_q = 32'hFFFFFFFE;
    tick();
    release dut.cnt_branch_q;
    for (int s = 0; s < 3; s++) set_slot(s, 1'b1, 1'b1, 1'b1, 10'(s), 32'h0);
    tick();
    clear_inputs();
    checks++;
    if (cnt_branch !== 32'hFFFFFFFF) begin
      errors++; $display("FAIL stats_saturate got=%h exp=ffffffff", cnt_branch);
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_nonbranch();
    test_correct_predict();
    test_mispredict();
    test_multi_mispredict();
    test_reset_in_flush();
    test_back_to_back();
`ifdef BRANCH_REDIRECT_STATS_EN
    test_stats_saturate();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
